// File: rtl/seq_generator.sv
// ---------------------------------------------------------------------------
// seq_generator
//
// Serial bit-sequence generator. On a start request in IDLE it captures a
// pattern, a (clamped) length and a repeat count, then shifts the pattern out
// MSB-first (bit len-1 first, bit 0 last) on the one-bit line `x`, one bit per
// clock, for reps+1 passes. A one-cycle `done` pulse marks the end of the
// sequence.
//
// Optional feature macro: SEQ_GEN_GAP_EN
//   defined     -> a GAP state inserts one idle bit (valid=0, x=0) between
//                  consecutive passes.
//   not defined -> passes are emitted back-to-back.
//
// Parameters:
//   WIDTH  maximum pattern length in bits
//   LEN_W  width of `len`; 2**LEN_W must exceed WIDTH
//   REP_W  width of `reps`
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   start    in   start request, honoured only in IDLE
//   pattern  in   bits to send
//   len      in   pattern length, values above WIDTH clamp to WIDTH
//   reps     in   extra passes (total passes = reps+1)
//   x        out  serial data (registered, forced to 0 when valid=0)
//   valid    out  x carries a pattern bit this cycle
//   busy     out  sequence in progress
//   done     out  one-cycle pulse after the last bit
// ---------------------------------------------------------------------------
module seq_generator #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
`ifdef SEQ_GEN_GAP_EN
    ST_GAP   = 2'd2,
`endif
    ST_DONE  = 2'd3
  } state_t;

  // Selects one pattern bit with an index that is wider than strictly
  // needed; written as a compare loop so the index width never has to
  // match the pattern's address width.
  function automatic logic bit_at(input logic [WIDTH-1:0] pat,
                                  input logic [LEN_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == LEN_W'(i)) begin
        b = pat[i];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pat_q,   pat_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic [REP_W-1:0]   pass_q,  pass_d;
  logic [LEN_W-1:0]   idx_q,   idx_d;
  logic               x_q,     x_d;
  logic               valid_q, valid_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic [LEN_W-1:0]   len_clamped_s;

  // Lengths beyond the pattern register are clamped to its full width.
  assign len_clamped_s = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

  // State, captured operands and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      pass_q  <= '0;
      idx_q   <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      pass_q  <= pass_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Outputs are computed for the cycle that follows the
  // edge, so x_d always carries the bit that idx_d points at; idx_q is the
  // index of the bit currently on the line.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    x_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d  = pattern;
          len_d  = len_clamped_s;
          pass_d = reps;
          if (len_clamped_s == {LEN_W{1'b0}}) begin
            // Empty pattern: report completion without emitting anything.
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SHIFT;
            idx_d   = len_clamped_s - LEN_W'(1);
            x_d     = bit_at(pattern, len_clamped_s - LEN_W'(1));
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (idx_q != {LEN_W{1'b0}}) begin
          idx_d   = idx_q - LEN_W'(1);
          x_d     = bit_at(pat_q, idx_q - LEN_W'(1));
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (pass_q != {REP_W{1'b0}}) begin
          // Bit 0 is on the line and more passes remain: rewind the index.
          pass_d = pass_q - REP_W'(1);
          idx_d  = len_q - LEN_W'(1);
`ifdef SEQ_GEN_GAP_EN
          state_d = ST_GAP;
          busy_d  = 1'b1;
`else
          state_d = ST_SHIFT;
          x_d     = bit_at(pat_q, len_q - LEN_W'(1));
          valid_d = 1'b1;
          busy_d  = 1'b1;
`endif
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

`ifdef SEQ_GEN_GAP_EN
      ST_GAP: begin
        // The index was already rewound when the gap was entered.
        state_d = ST_SHIFT;
        x_d     = bit_at(pat_q, idx_q);
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
`endif

      ST_DONE: begin
        // start is deliberately not looked at here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign x     = x_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
